exmem_buffer: RTL
=================

Name: exmem_buffer

Overview:
- Execute-to-memory pipeline buffer directly downstream of the ALU.
- Captures the ALU result plus the decoded side-band fields of each instruction into a small FIFO and presents them to the memory stage over a valid/ready handshake.
- Performs signed-overflow detection for trapping add/sub and supports pipeline flush.
- Has no combinational path from any in_* port to any out_* port.

Parameters:
- DEPTH, 2, number of buffered entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered entries and any same-cycle push.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  buffer can accept an entry; driven from registers only.
- in_pc  in  32  instruction PC.
- in_funct  in  4  ALU function code that produced in_result.
- in_a  in  32  ALU operand 1.
- in_b  in  32  ALU operand 2.
- in_result  in  32  ALU output.
- in_trap_ov  in  1  instruction traps on overflow (ADD/SUB, not ADDU/SUBU).
- in_wen  in  1  register write enable.
- in_dst  in  5  destination register.
- out_valid  out  1  head entry present.
- out_ready  in  1  memory stage accepts the head entry.
- out_pc  out  32  head PC.
- out_result  out  32  head result.
- out_wen  out  1  head write enable, after overflow suppression.
- out_dst  out  5  head destination register.
- out_exc_ov  out  1  head raised an overflow exception.

Behaviour:
- Clocking and reset: single clock clk; reset resetn is asynchronous, active-low.
- While resetn=0:
  - count=0, read/write pointers=0, out_valid=0, in_ready=1.
  - All out_* data ports = 0; storage contents cleared.
  - Reset asserted mid-transfer drops every entry; nothing is replayed.
- Push and pop:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready.
  - An entry pushed at edge N is visible on out_* after edge N (latency 1 cycle).
- Ready and valid:
  - in_ready = (count != DEPTH). It does not depend on out_ready, so no bypass when full.
  - out_valid = (count != 0).
  - Head fields are stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Empty and full:
  - Empty with in_valid=1: entry appears next cycle; nothing is presented combinationally.
  - Full: in_ready=0 and upstream holds its entry.
- Wrap-around: pointers are PTR_W bits wide and wrap modulo DEPTH.
- Overflow detection, computed at push:
  - in_funct=4'b0000 (add): ov = (a[31]==b[31]) & (r[31]!=a[31]).
  - in_funct=4'b0001 (sub): ov = (a[31]!=b[31]) & (r[31]!=a[31]).
  - Any other funct: ov=0.
  - Stored exc_ov = ov & in_trap_ov; stored wen = in_wen & ~exc_ov.
  - The result is stored unchanged even when exc_ov=1.
- Flush:
  - At the next edge, count=0, pointers=0, out_valid=0.
  - A pop in the same cycle as flush is still a completed handshake for the memory stage.
  - Flush has priority over push.

Optional Feature:
EXMEM_FWD_EN
- Defined:
  - Adds input fwd_rs (5) and outputs fwd_hit (1) and fwd_data (32).
  - Combinational lookup over registered state only.
  - fwd_hit=1 when some valid entry has wen=1, dst==fwd_rs and fwd_rs!=0.
  - fwd_data = result of the youngest such entry; 0 when no hit.
  - No lookup into the in_* ports.
- Undefined: these ports and the lookup logic do not exist.

Decomposition:
- Package exmem_pkg holds:
  - alu_funct_t constants: ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_OR=4'b0011, ALU_NOR=4'b0100, ALU_XOR=4'b0101, ALU_SRA=4'b0110, ALU_SRL=4'b0111, ALU_SLTU=4'b1000, ALU_SLT=4'b1001, ALU_PASSB=4'b1111.
  - Packed struct exmem_entry_t {pc, result, wen, dst, exc_ov}.
- One sub-module, ov_check: combinational, (funct, a, b, r) -> ov.
- Storage and pointer logic stay in exmem_buffer.

Test Plan:
- Reset: resetn=0 mid-stream with 2 entries held -> out_valid=0, in_ready=1, out_result=0 immediately, without waiting for a clock edge.
- Pass-through: push {pc=0x1000, result=0x5, wen=1, dst=3} with out_ready=1 -> out_valid=1 next cycle with identical fields; steady one entry per cycle on back-to-back pushes.
- Backpressure: out_ready=0, push 3 entries -> in_ready=0 after entry 2, entry 3 held upstream; release -> entries drain in order 1, 2, 3, no loss or duplication.
- Overflow: funct=0000, a=0x7FFFFFFF, b=1, r=0x80000000, trap_ov=1 -> out_exc_ov=1, out_wen=0, out_result=0x80000000. Same with trap_ov=0 -> exc_ov=0, wen=1. funct=0001, a=0x80000000, b=1 -> exc_ov=1.
- Flush: 2 entries buffered, flush=1 together with in_valid=1 -> next cycle out_valid=0, count=0, flushed push never appears.
- Forwarding (EXMEM_FWD_EN): entries dst=5/result=0xA (older) and dst=5/result=0xB (younger), fwd_rs=5 -> fwd_hit=1, fwd_data=0xB; fwd_rs=0 -> fwd_hit=0.

Source files
------------

// File: rtl/exmem_pkg.sv
// exmem_pkg: ALU function codes and the buffered entry layout shared by the EX/MEM buffer.
package exmem_pkg;
    typedef logic [3:0] alu_funct_t;
    localparam alu_funct_t ALU_ADD   = 4'b0000;
    localparam alu_funct_t ALU_SUB   = 4'b0001;
    localparam alu_funct_t ALU_AND   = 4'b0010;
    localparam alu_funct_t ALU_OR    = 4'b0011;
    localparam alu_funct_t ALU_NOR   = 4'b0100;
    localparam alu_funct_t ALU_XOR   = 4'b0101;
    localparam alu_funct_t ALU_SRA   = 4'b0110;
    localparam alu_funct_t ALU_SRL   = 4'b0111;
    localparam alu_funct_t ALU_SLTU  = 4'b1000;
    localparam alu_funct_t ALU_SLT   = 4'b1001;
    localparam alu_funct_t ALU_PASSB = 4'b1111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic        wen;
        logic [4:0]  dst;
        logic        exc_ov;
    } exmem_entry_t;
endpackage

// File: rtl/ov_check.sv
// ov_check: signed overflow of an add/sub judged from operand and result signs.
module ov_check
    import exmem_pkg::*;
(
    input  logic [3:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] r,
    output logic        ov
);
    logic na, nb, nr;
    assign na = $signed(a) < 0;
    assign nb = $signed(b) < 0;
    assign nr = $signed(r) < 0;
    always_comb ov = (funct == ALU_ADD) ? (na == nb) && (nr != na) :
                     (funct == ALU_SUB) ? (na != nb) && (nr != na) : 1'b0;
endmodule

// File: rtl/exmem_buffer.sv
// exmem_buffer: EX->MEM FIFO buffer with overflow trap and flush; EXMEM_FWD_EN adds a
// register-only forwarding lookup (fwd_rs -> fwd_hit/fwd_data).
module exmem_buffer
    import exmem_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [3:0]  in_funct,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_result,
    input  logic        in_trap_ov,
    input  logic        in_wen,
    input  logic [4:0]  in_dst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_result,
    output logic        out_wen,
    output logic [4:0]  out_dst,
    output logic        out_exc_ov
`ifdef EXMEM_FWD_EN
    ,
    input  logic [4:0]  fwd_rs,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
`endif
);
    exmem_entry_t     mem [DEPTH];
    exmem_entry_t     entry, head;
    logic [PTR_W-1:0] rptr, wptr;
    logic [PTR_W:0]   count;
    logic             ov, exc, push, pop;

    ov_check u_ov (
        .funct (in_funct),
        .a     (in_a),
        .b     (in_b),
        .r     (in_result),
        .ov    (ov)
    );

    assign exc       = ov & in_trap_ov;
    assign in_ready  = count != (PTR_W+1)'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        entry = '{pc: in_pc, result: in_result, wen: in_wen & ~exc, dst: in_dst, exc_ov: exc};
        head  = out_valid ? mem[rptr] : '0;
    end

    assign out_pc     = head.pc;
    assign out_result = head.result;
    assign out_wen    = head.wen;
    assign out_dst    = head.dst;
    assign out_exc_ov = head.exc_ov;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= entry;
                wptr      <= wptr + PTR_W'(1);
            end
            if (pop) rptr <= rptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

`ifdef EXMEM_FWD_EN
    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PTR_W+1)'(i) < count && mem[rptr + PTR_W'(i)].wen &&
                mem[rptr + PTR_W'(i)].dst == fwd_rs && fwd_rs != '0) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[rptr + PTR_W'(i)].result;
            end
        end
    end
`endif
endmodule
